// File: rtl/upg_loader_if.sv
// Byte-stream input and memory upgrade write port of the boot loader.
// slave = loader side, master = UART/memory side.
interface upg_loader_if #(
  parameter int ADDR_W = 14
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              upg_wen;
  logic [ADDR_W-1:0] upg_adr;
  logic [31:0]       upg_dat;
  logic              upg_done;
  logic              upg_err;
  logic              upg_busy;

  modport slave (
    input  rx_valid, rx_data,
    output upg_wen, upg_adr, upg_dat, upg_done, upg_err, upg_busy
  );

  modport master (
    output rx_valid, rx_data,
    input  upg_wen, upg_adr, upg_dat, upg_done, upg_err, upg_busy
  );
endinterface

// File: rtl/upg_loader.sv
// Boot loader: checks HEADER/LEN/data/CSUM frames and writes little-endian words.
// Optional UPG_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled frame.
module upg_loader #(
  parameter logic [7:0] HEADER      = 8'h5A,
  parameter int         ADDR_W      = 14,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic         upg_clk,
  input  logic         upg_rst,
  upg_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       shift_q, shift_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       len_full;
  logic              last_word;

`ifdef UPG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    csum_d     = csum_q;
    shift_d    = shift_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
`ifdef UPG_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == HEADER) state_d = LEN0;
          else                       state_d = IDLE;
        end
        LEN0: begin
          len_d[7:0] = bus.rx_data;
          state_d    = LEN1;
        end
        LEN1: begin
          len_d      = len_full;
          word_cnt_d = '0;
          lane_d     = 2'd0;
          csum_d     = 8'd0;
          if ({1'b0, len_full} > LEN_MAX) state_d = ERR;
          else if (len_full == 16'd0)     state_d = CSUM;
          else                            state_d = DATA;
        end
        DATA: begin
          csum_d = csum_q ^ bus.rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: shift_d[7:0]   = bus.rx_data;
            2'd1: shift_d[15:8]  = bus.rx_data;
            2'd2: shift_d[23:16] = bus.rx_data;
            2'd3: begin
              // Fourth byte completes the word; it goes straight to the write port.
              wen_d      = 1'b1;
              adr_d      = word_cnt_q[ADDR_W-1:0];
              dat_d      = {bus.rx_data, shift_q};
              word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
              if (last_word) state_d = CSUM;
              else           state_d = DATA;
            end
            default: lane_d = 2'd0;
          endcase
        end
        CSUM: begin
          if (bus.rx_data == csum_q) state_d = DONE;
          else                       state_d = ERR;
        end
        DONE, ERR: begin
          if (bus.rx_data == HEADER) state_d = LEN0;
          else                       state_d = state_q;
        end
        default: state_d = IDLE;
      endcase
`ifdef UPG_TIMEOUT_EN
      tmo_d = '0;
`endif
    end else begin
`ifdef UPG_TIMEOUT_EN
      if (busy_q) begin
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = ERR;
        else                               state_d = state_q;
        tmo_d = tmo_q + TW'(1);
      end else begin
        tmo_d = '0;
      end
`else
      state_d = state_q;
`endif
    end
    busy_d = (state_d == LEN0) || (state_d == LEN1) ||
             (state_d == DATA) || (state_d == CSUM);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge upg_clk) begin
    if (upg_rst) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      word_cnt_q <= '0;
      lane_q     <= 2'd0;
      csum_q     <= 8'd0;
      shift_q    <= 24'd0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UPG_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      csum_q     <= csum_d;
      shift_q    <= shift_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef UPG_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.upg_wen  = wen_q;
  assign bus.upg_adr  = adr_q;
  assign bus.upg_dat  = dat_q;
  assign bus.upg_done = done_q;
  assign bus.upg_err  = err_q;
  assign bus.upg_busy = busy_q;

endmodule

// File: doc/upg_loader.md
Name: upg_loader

Overview:
- Boot-programming front end for the instruction and data memories.
- Consumes the byte stream from the UART receiver, checks the frame format, and assembles bytes into little-endian 32-bit words.
- Drives the memory upgrade write port: upg_wen, upg_adr, upg_dat, upg_done.
- Runs entirely in the upgrade clock domain. The memories switch back to CPU control once upg_done is high.

Parameters:
- HEADER, 8'h5A: start-of-frame byte.
- ADDR_W, 14: word-address width of the target memory. Maximum word count is 2**ADDR_W.
- TIMEOUT_CYC, 1000000: inter-byte timeout in upg_clk cycles. Used only when UPG_TIMEOUT_EN is defined.

Ports:
- upg_clk, input, 1: single clock for the whole block.
- upg_rst, input, 1: synchronous, active-high reset.
- rx_valid, input, 1: one-cycle strobe; a received byte is present on rx_data.
- rx_data, input, 8: received byte. Sampled only when rx_valid=1.
- upg_wen, output, 1: one-cycle memory write strobe.
- upg_adr, output, ADDR_W: word address for the write.
- upg_dat, output, 32: write data word.
- upg_done, output, 1: image loaded and checksum verified. Sticky.
- upg_err, output, 1: frame error. Sticky until the next header.
- upg_busy, output, 1: a frame is in progress (any state other than IDLE, DONE or ERR).

Behaviour:
- Reset: all outputs are 0. State goes to IDLE. Byte counter, word counter, length and checksum registers are cleared.
- A synchronous reset in any state, including mid-frame, aborts immediately. No write strobe is issued in the reset cycle or the cycle after it.
- Frame format, byte by byte: HEADER, LEN[7:0], LEN[15:8], then LEN*4 data bytes (little-endian per word), then CSUM.
  - CSUM is the XOR of all data bytes.
- States and transitions:
  - IDLE: a byte equal to HEADER goes to LEN0. Any other byte is ignored.
  - LEN0: latch the length low byte; go to LEN1.
  - LEN1: latch the length high byte.
    - LEN > 2**ADDR_W goes to ERR.
    - LEN = 0 goes to CSUM.
    - Otherwise go to DATA. Word counter=0, byte lane=0, checksum=0.
  - DATA: each byte is written into lane[1:0] of the word shift register (lane 0 = bits 7:0) and XORed into the checksum; lane then increments.
    - On lane 3, the next cycle gives: upg_wen=1 for exactly one cycle, upg_adr=word counter, upg_dat=assembled word.
    - The word counter then increments.
    - After word LEN-1 is accepted, go to CSUM.
  - CSUM: byte equals the checksum goes to DONE. Otherwise go to ERR.
  - DONE: upg_done=1. A HEADER byte clears upg_done and goes to LEN0 (re-programming). Other bytes are ignored.
  - ERR: upg_err=1, upg_done=0. A HEADER byte clears upg_err and goes to LEN0. Other bytes are ignored.
- Timing:
  - upg_wen latency is exactly 1 cycle after the rx_valid carrying byte 3 of a word.
  - upg_adr and upg_dat are stable during the upg_wen cycle and hold until the next write.
- Back-to-back rx_valid on consecutive cycles must be accepted with no lost byte.
- A write strobe coinciding with the next rx_valid is processed in the same cycle, with no stall.
- The word counter never wraps. LEN = 2**ADDR_W writes addresses 0 to 2**ADDR_W-1 and then proceeds to CSUM.
- Writes already issued before an error are not rolled back. upg_done=0 keeps the memories in upgrade mode.
- upg_busy=1 in LEN0, LEN1, DATA and CSUM.

Optional Feature:
- Macro: UPG_TIMEOUT_EN.
- With the macro defined:
  - A counter is cleared on every rx_valid and increments while upg_busy=1.
  - On reaching TIMEOUT_CYC without a byte, the block goes to ERR (upg_err=1) and drops any partial word without writing it.
  - The counter is idle in IDLE, DONE and ERR.
- Without the macro: no counter exists; a stalled frame waits indefinitely.

Test Plan:
- Basic load: 5A 02 00 11 22 33 44 AA BB CC DD, then CSUM 0x00 ^ (11^22^33^44^AA^BB^CC^DD).
  - Required: upg_wen at adr 0 with 0x44332211, then at adr 1 with 0xDDCCBBAA.
  - Required: upg_done=1 and upg_err=0 after CSUM.
- Bad checksum: same frame with CSUM inverted.
  - Required: two writes occur, then upg_err=1 and upg_done=0.
  - Required: a following valid frame clears upg_err and sets upg_done.
- Length limits, ADDR_W=14:
  - LEN=0x4001 gives upg_err=1 with no writes.
  - LEN=0 followed by CSUM 0x00 gives upg_done=1 with no writes.
- Noise and back-to-back:
  - Bytes 00 FF 13 before the header are ignored.
  - Data delivered with rx_valid held high on consecutive cycles produces every write at a 4-cycle spacing with correct data.
- Reset mid-frame: assert upg_rst after the 2nd data byte.
  - Required: all outputs 0 and no upg_wen.
  - Required: a fresh frame loads correctly starting at adr 0.
- With UPG_TIMEOUT_EN and TIMEOUT_CYC=100: stop sending after 3 data bytes.
  - Required: upg_err=1 at cycle 100 after the last byte, with no write.
  - Without the macro, the same stimulus leaves upg_busy=1 indefinitely.
